// File: rtl/alarm_sched.sv
// rtl/alarm_sched.sv - digit-entry FSM for clock/alarm time plus alarm ring/snooze FSM
// Optional snooze state and target logic: define ALARM_SCHED_SNOOZE_EN.
module alarm_sched #(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] second,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       set_time,
    input  logic       set_alarm,
    input  logic       alarm_en,
    input  logic       btn_snooze,
    input  logic       btn_stop,
    output logic [3:0] hour1,
    output logic [3:0] hour0,
    output logic [3:0] minute1,
    output logic [3:0] minute0,
    output logic [5:0] alarm_hour,
    output logic [5:0] alarm_minute,
    output logic       ringing,
    output logic       entry_busy,
    output logic       entry_err
);
    typedef enum logic [2:0] {E_IDLE, E_H1, E_H0, E_M1, E_M0, E_CHECK, E_COMMIT} e_state_t;
    typedef enum logic [1:0] {A_WAIT, A_RING, A_SNOOZE} a_state_t;

    e_state_t   e_q;
    a_state_t   a_q;
    logic       tgt_time_q;
    logic [3:0] d_h1_q, d_h0_q, d_m1_q, d_m0_q;
    logic [3:0] hour1_q, hour0_q, minute1_q, minute0_q;
    logic [5:0] alarm_hour_q, alarm_minute_q;
    logic       busy_q, err_q, ringing_q;
    logic [5:0] ring_cnt_q, sec_prev_q;
    logic [6:0] hours_v, mins_v;
    logic       digit_ok, alarm_commit, sec_edge, at_alarm, stop_req;

    assign digit_ok     = (key_digit <= 4'd9);
    assign hours_v      = 7'(d_h1_q) * 7'd10 + 7'(d_h0_q);
    assign mins_v       = 7'(d_m1_q) * 7'd10 + 7'(d_m0_q);
    assign alarm_commit = (e_q == E_COMMIT) && !tgt_time_q;
    assign sec_edge     = (second != sec_prev_q);
    assign at_alarm     = (second == 6'd0) && (hour == alarm_hour_q) && (minute == alarm_minute_q);

`ifdef ALARM_SCHED_SNOOZE_EN
    logic [5:0] snz_hour_q, snz_min_q, snz_hour_d, snz_min_d;
    logic [6:0] snz_sum;
    logic       at_snooze;

    assign stop_req  = btn_stop;
    assign snz_sum   = {1'b0, minute} + 7'(SNOOZE_MIN);
    assign at_snooze = (second == 6'd0) && (hour == snz_hour_q) && (minute == snz_min_q);

    always_comb begin
        snz_min_d  = snz_sum[5:0];
        snz_hour_d = hour;
        if (snz_sum >= 7'd60) begin
            snz_min_d  = 6'(snz_sum - 7'd60);
            snz_hour_d = (hour >= 6'd23) ? 6'd0 : hour + 6'd1;
        end
    end
`else
    // Without a snooze state the snooze key simply silences the alarm.
    assign stop_req = btn_stop | (btn_snooze && (SNOOZE_MIN > 0));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q            <= E_IDLE;
            tgt_time_q     <= 1'b0;
            d_h1_q         <= 4'd0;
            d_h0_q         <= 4'd0;
            d_m1_q         <= 4'd0;
            d_m0_q         <= 4'd0;
            hour1_q        <= 4'hA;
            hour0_q        <= 4'hA;
            minute1_q      <= 4'hA;
            minute0_q      <= 4'hA;
            alarm_hour_q   <= 6'd0;
            alarm_minute_q <= 6'd0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            err_q     <= 1'b0;
            hour1_q   <= 4'hA;
            hour0_q   <= 4'hA;
            minute1_q <= 4'hA;
            minute0_q <= 4'hA;
            unique case (e_q)
                E_IDLE: if (set_time || set_alarm) begin
                    e_q        <= E_H1;
                    tgt_time_q <= set_time;
                    busy_q     <= 1'b1;
                end
                E_H1, E_H0, E_M1, E_M0: if (key_valid) begin
                    if (!digit_ok) begin
                        e_q    <= E_IDLE;
                        busy_q <= 1'b0;
                        err_q  <= 1'b1;
                    end else begin
                        unique case (e_q)
                            E_H1:    begin d_h1_q <= key_digit; e_q <= E_H0;    end
                            E_H0:    begin d_h0_q <= key_digit; e_q <= E_M1;    end
                            E_M1:    begin d_m1_q <= key_digit; e_q <= E_M0;    end
                            default: begin d_m0_q <= key_digit; e_q <= E_CHECK; end
                        endcase
                    end
                end
                E_CHECK: if (hours_v > 7'd23 || mins_v > 7'd59) begin
                    e_q    <= E_IDLE;
                    busy_q <= 1'b0;
                    err_q  <= 1'b1;
                end else begin
                    // Set digits are registered here so they appear exactly during E_COMMIT.
                    e_q <= E_COMMIT;
                    if (tgt_time_q) begin
                        hour1_q   <= d_h1_q;
                        hour0_q   <= d_h0_q;
                        minute1_q <= d_m1_q;
                        minute0_q <= d_m0_q;
                    end
                end
                default: begin
                    e_q    <= E_IDLE;
                    busy_q <= 1'b0;
                    if (alarm_commit) begin
                        alarm_hour_q   <= hours_v[5:0];
                        alarm_minute_q <= mins_v[5:0];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= A_WAIT;
            ringing_q  <= 1'b0;
            ring_cnt_q <= 6'd0;
            sec_prev_q <= second;
`ifdef ALARM_SCHED_SNOOZE_EN
            snz_hour_q <= 6'd0;
            snz_min_q  <= 6'd0;
`endif
        end else begin
            sec_prev_q <= second;
            if (!alarm_en || alarm_commit) begin
                a_q       <= A_WAIT;
                ringing_q <= 1'b0;
            end else begin
                unique case (a_q)
                    A_WAIT: if (sec_edge && at_alarm) begin
                        a_q        <= A_RING;
                        ringing_q  <= 1'b1;
                        ring_cnt_q <= 6'd0;
                    end
                    A_RING: if (stop_req) begin
                        a_q       <= A_WAIT;
                        ringing_q <= 1'b0;
`ifdef ALARM_SCHED_SNOOZE_EN
                    end else if (btn_snooze) begin
                        a_q        <= A_SNOOZE;
                        ringing_q  <= 1'b0;
                        snz_hour_q <= snz_hour_d;
                        snz_min_q  <= snz_min_d;
`endif
                    end else if (sec_edge) begin
                        if (ring_cnt_q == 6'(RING_SEC - 1)) begin
                            a_q       <= A_WAIT;
                            ringing_q <= 1'b0;
                        end else begin
                            ring_cnt_q <= ring_cnt_q + 6'd1;
                        end
                    end
`ifdef ALARM_SCHED_SNOOZE_EN
                    A_SNOOZE: if (btn_stop) begin
                        a_q <= A_WAIT;
                    end else if (sec_edge && at_snooze) begin
                        a_q        <= A_RING;
                        ringing_q  <= 1'b1;
                        ring_cnt_q <= 6'd0;
                    end
`endif
                    default: begin
                        a_q       <= A_WAIT;
                        ringing_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign hour1        = hour1_q;
    assign hour0        = hour0_q;
    assign minute1      = minute1_q;
    assign minute0      = minute0_q;
    assign alarm_hour   = alarm_hour_q;
    assign alarm_minute = alarm_minute_q;
    assign ringing      = ringing_q;
    assign entry_busy   = busy_q;
    assign entry_err    = err_q;
endmodule

// File: tb/tb_alarm_sched.sv
// tb/tb_alarm_sched.sv - directed self-checking bench for alarm_sched
module tb_alarm_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] hour = 6'd0, minute = 6'd0, second = 6'd0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       set_time = 1'b0, set_alarm = 1'b0, alarm_en = 1'b0;
    logic       btn_snooze = 1'b0, btn_stop = 1'b0;
    logic [3:0] hour1, hour0, minute1, minute0;
    logic [5:0] alarm_hour, alarm_minute;
    logic       ringing, entry_busy, entry_err;
    int         passed = 0;
    int         total  = 0;

    alarm_sched #(.SNOOZE_MIN(5), .RING_SEC(60)) dut (
        .clk(clk), .rst(rst), .hour(hour), .minute(minute), .second(second),
        .key_valid(key_valid), .key_digit(key_digit), .set_time(set_time),
        .set_alarm(set_alarm), .alarm_en(alarm_en), .btn_snooze(btn_snooze),
        .btn_stop(btn_stop), .hour1(hour1), .hour0(hour0), .minute1(minute1),
        .minute0(minute0), .alarm_hour(alarm_hour), .alarm_minute(alarm_minute),
        .ringing(ringing), .entry_busy(entry_busy), .entry_err(entry_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = a; step();
        key_digit = b; step();
        key_digit = c; step();
        key_digit = d; step();
        key_valid = 1'b0;
    endtask

    task automatic start_entry(input bit is_time);
        set_time  = is_time;
        set_alarm = !is_time;
        step();
        set_time  = 1'b0;
        set_alarm = 1'b0;
    endtask

    task automatic set_clock(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
        hour = h; minute = m; second = s;
        step();
    endtask

    task automatic chk_set_idle(input string tag);
        chk({tag, "_h1"}, {4'd0, hour1}, 8'hA);
        chk({tag, "_h0"}, {4'd0, hour0}, 8'hA);
        chk({tag, "_m1"}, {4'd0, minute1}, 8'hA);
        chk({tag, "_m0"}, {4'd0, minute0}, 8'hA);
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        step();
        chk_set_idle("reset");
        chk("reset_ahour", {2'd0, alarm_hour}, 8'd0);
        chk("reset_amin", {2'd0, alarm_minute}, 8'd0);
        chk("reset_ring", {7'd0, ringing}, 8'd0);
        chk("reset_busy", {7'd0, entry_busy}, 8'd0);
        chk("reset_err", {7'd0, entry_err}, 8'd0);

        // Clock-time entry 13:45
        start_entry(1'b1);
        chk("t_busy", {7'd0, entry_busy}, 8'd1);
        set_digits(4'd1, 4'd3, 4'd4, 4'd5);
        chk_set_idle("t_check");
        step();
        chk("t_h1", {4'd0, hour1}, 8'd1);
        chk("t_h0", {4'd0, hour0}, 8'd3);
        chk("t_m1", {4'd0, minute1}, 8'd4);
        chk("t_m0", {4'd0, minute0}, 8'd5);
        chk("t_err", {7'd0, entry_err}, 8'd0);
        step();
        chk_set_idle("t_after");
        chk("t_busy_done", {7'd0, entry_busy}, 8'd0);

        // Alarm entry 24:00 rejected, then 07:30 accepted
        start_entry(1'b0);
        set_digits(4'd2, 4'd4, 4'd0, 4'd0);
        step();
        chk("a_bad_err", {7'd0, entry_err}, 8'd1);
        chk("a_bad_busy", {7'd0, entry_busy}, 8'd0);
        step();
        chk("a_bad_err_pulse", {7'd0, entry_err}, 8'd0);
        chk("a_bad_ahour", {2'd0, alarm_hour}, 8'd0);
        chk("a_bad_amin", {2'd0, alarm_minute}, 8'd0);
        start_entry(1'b0);
        set_digits(4'd0, 4'd7, 4'd3, 4'd0);
        step();
        chk_set_idle("a_commit");
        step();
        chk("a_ahour", {2'd0, alarm_hour}, 8'd7);
        chk("a_amin", {2'd0, alarm_minute}, 8'd30);

        // Ring at 07:30:00 and auto-stop after 60 second edges
        alarm_en = 1'b1;
        set_clock(6'd7, 6'd29, 6'd59);
        step();
        chk("r_before", {7'd0, ringing}, 8'd0);
        set_clock(6'd7, 6'd30, 6'd0);
        chk("r_start", {7'd0, ringing}, 8'd1);
        for (int k = 1; k <= 60; k++) begin
            if (k == 60) set_clock(6'd7, 6'd31, 6'd0);
            else         set_clock(6'd7, 6'd30, 6'(k));
            if (k == 59) chk("r_edge59", {7'd0, ringing}, 8'd1);
        end
        chk("r_edge60", {7'd0, ringing}, 8'd0);

        // Alarm 23:58, snooze wrapping to 00:03
        start_entry(1'b0);
        set_digits(4'd2, 4'd3, 4'd5, 4'd8);
        step(); step();
        chk("s_ahour", {2'd0, alarm_hour}, 8'd23);
        chk("s_amin", {2'd0, alarm_minute}, 8'd58);
        set_clock(6'd23, 6'd57, 6'd59);
        set_clock(6'd23, 6'd58, 6'd0);
        chk("s_ring", {7'd0, ringing}, 8'd1);
        set_clock(6'd23, 6'd58, 6'd5);
        btn_snooze = 1'b1; step(); btn_snooze = 1'b0;
        chk("s_quiet", {7'd0, ringing}, 8'd0);
        set_clock(6'd0, 6'd2, 6'd59);
        chk("s_early", {7'd0, ringing}, 8'd0);
        set_clock(6'd0, 6'd3, 6'd0);
`ifdef ALARM_SCHED_SNOOZE_EN
        chk("s_rering", {7'd0, ringing}, 8'd1);
        btn_stop = 1'b1; step(); btn_stop = 1'b0;
        chk("s_stop", {7'd0, ringing}, 8'd0);
`else
        chk("s_no_rering", {7'd0, ringing}, 8'd0);
`endif

        // Stop and snooze together: stop wins, no re-ring at target
        set_clock(6'd23, 6'd57, 6'd59);
        set_clock(6'd23, 6'd58, 6'd0);
        chk("b_ring", {7'd0, ringing}, 8'd1);
        btn_snooze = 1'b1; btn_stop = 1'b1; step();
        btn_snooze = 1'b0; btn_stop = 1'b0;
        chk("b_quiet", {7'd0, ringing}, 8'd0);
        set_clock(6'd0, 6'd2, 6'd59);
        set_clock(6'd0, 6'd3, 6'd0);
        chk("b_no_rering", {7'd0, ringing}, 8'd0);

        // Disarm while ringing
        set_clock(6'd23, 6'd57, 6'd59);
        set_clock(6'd23, 6'd58, 6'd0);
        chk("d_ring", {7'd0, ringing}, 8'd1);
        alarm_en = 1'b0; step(); alarm_en = 1'b1;
        chk("d_off", {7'd0, ringing}, 8'd0);
        step();
        chk("d_stay_off", {7'd0, ringing}, 8'd0);

        // Alarm commit while ringing returns to wait; entry does not block ringing
        set_clock(6'd23, 6'd57, 6'd59);
        set_clock(6'd23, 6'd58, 6'd0);
        start_entry(1'b0);
        set_digits(4'd0, 4'd6, 4'd0, 4'd0);
        chk("c_ring_during_entry", {7'd0, ringing}, 8'd1);
        step(); step();
        chk("c_ring_stopped", {7'd0, ringing}, 8'd0);
        chk("c_ahour", {2'd0, alarm_hour}, 8'd6);

        // Illegal digit at minute tens
        start_entry(1'b1);
        key_valid = 1'b1;
        key_digit = 4'd1; step();
        key_digit = 4'd2; step();
        key_digit = 4'hB; step();
        key_valid = 1'b0;
        chk("k_err", {7'd0, entry_err}, 8'd1);
        chk("k_busy", {7'd0, entry_busy}, 8'd0);

        // Reset mid-entry discards digits
        start_entry(1'b1);
        key_valid = 1'b1; key_digit = 4'd1; step(); key_valid = 1'b0;
        chk("x_busy", {7'd0, entry_busy}, 8'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk_set_idle("x_rst");
        chk("x_ahour", {2'd0, alarm_hour}, 8'd0);
        chk("x_amin", {2'd0, alarm_minute}, 8'd0);
        chk("x_ring", {7'd0, ringing}, 8'd0);
        chk("x_busy_rst", {7'd0, entry_busy}, 8'd0);
        chk("x_err", {7'd0, entry_err}, 8'd0);
        set_digits(4'd2, 4'd3, 4'd4, 4'd5);
        step();
        chk("x_ignored_busy", {7'd0, entry_busy}, 8'd0);
        chk_set_idle("x_ignored");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
